// File: rtl/rectifier_adc_sequencer.sv
// Sequences the Ibat/Vbat AD7822 pair: periodic CONVST, wait for both EOCs, read each, publish held samples.
// Optional RECT_ADC_AVG_EN: outputs become the truncated mean of the last four raw samples per channel.
module rectifier_adc_sequencer #(
  parameter int SAMPLE_DIV  = 500,
  parameter int CONVST_W    = 3,
  parameter int EOC_TIMEOUT = 50,
  parameter int RD_W        = 4
) (
  input  logic       i_CLK,
  input  logic       i_RST_n,
  input  logic       i_enable,
  input  logic       i_EOC_I_n,
  input  logic       i_EOC_V_n,
  input  logic [7:0] i_DATA_I,
  input  logic [7:0] i_DATA_V,
  output logic       o_CONVST_n,
  output logic       o_CS_I_n,
  output logic       o_RD_I_n,
  output logic       o_CS_V_n,
  output logic       o_RD_V_n,
  output logic [7:0] o_Ibat_ADC,
  output logic [7:0] o_Vbat_ADC,
  output logic       o_valid,
  output logic       o_fault,
  output logic       o_busy
);

  typedef enum logic [2:0] {IDLE, CONV, WAIT, RD_I, RD_V, UPDATE} state_t;

  localparam int PW = $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(EOC_TIMEOUT + CONVST_W + RD_W + 1);
  localparam logic [PW-1:0] RELOAD    = PW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] CONV_LAST = SW'(CONVST_W - 1);
  localparam logic [SW-1:0] WAIT_LAST = SW'(EOC_TIMEOUT - 1);
  localparam logic [SW-1:0] RD_LAST   = SW'(RD_W - 1);

  state_t        state;
  logic [PW-1:0] period_cnt;
  logic [SW-1:0] st_cnt;
  logic          eoc_i_meta, eoc_i_sync, eoc_v_meta, eoc_v_sync;
  logic          seen_i, seen_v;
  logic [7:0]    shadow_i, shadow_v;
  logic          tick;

  assign tick = i_enable && (period_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      period_cnt <= RELOAD;
    end else if (!i_enable || period_cnt == '0) begin
      period_cnt <= RELOAD;
    end else begin
      period_cnt <= period_cnt - PW'(1);
    end
  end

  // NOTE: EOC lines are asynchronous to i_CLK; only the second flop of each pair may be used.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      {eoc_i_sync, eoc_i_meta} <= 2'b11;
      {eoc_v_sync, eoc_v_meta} <= 2'b11;
    end else begin
      {eoc_i_sync, eoc_i_meta} <= {eoc_i_meta, i_EOC_I_n};
      {eoc_v_sync, eoc_v_meta} <= {eoc_v_meta, i_EOC_V_n};
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state      <= IDLE;
      st_cnt     <= '0;
      seen_i     <= 1'b0;
      seen_v     <= 1'b0;
      o_CONVST_n <= 1'b1;
      o_CS_I_n   <= 1'b1;
      o_RD_I_n   <= 1'b1;
      o_CS_V_n   <= 1'b1;
      o_RD_V_n   <= 1'b1;
      shadow_i   <= '0;
      shadow_v   <= '0;
      o_valid    <= 1'b0;
      o_fault    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state      <= CONV;
            st_cnt     <= '0;
            seen_i     <= 1'b0;
            seen_v     <= 1'b0;
            o_CONVST_n <= 1'b0;
            o_busy     <= 1'b1;
          end
        end
        CONV: begin
          seen_i <= seen_i | ~eoc_i_sync;
          seen_v <= seen_v | ~eoc_v_sync;
          if (st_cnt == CONV_LAST) begin
            state      <= WAIT;
            st_cnt     <= '0;
            o_CONVST_n <= 1'b1;
          end else begin
            st_cnt <= st_cnt + SW'(1);
          end
        end
        WAIT: begin
          seen_i <= seen_i | ~eoc_i_sync;
          seen_v <= seen_v | ~eoc_v_sync;
          if (seen_i && seen_v) begin
            state    <= RD_I;
            st_cnt   <= '0;
            o_CS_I_n <= 1'b0;
            o_RD_I_n <= 1'b0;
          end else if (st_cnt == WAIT_LAST) begin
            state   <= IDLE;
            o_fault <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            st_cnt <= st_cnt + SW'(1);
          end
        end
        RD_I: begin
          if (st_cnt == RD_LAST) begin
            state    <= RD_V;
            st_cnt   <= '0;
            shadow_i <= i_DATA_I;
            o_CS_I_n <= 1'b1;
            o_RD_I_n <= 1'b1;
            o_CS_V_n <= 1'b0;
            o_RD_V_n <= 1'b0;
          end else begin
            st_cnt <= st_cnt + SW'(1);
          end
        end
        RD_V: begin
          if (st_cnt == RD_LAST) begin
            state    <= UPDATE;
            st_cnt   <= '0;
            shadow_v <= i_DATA_V;
            o_CS_V_n <= 1'b1;
            o_RD_V_n <= 1'b1;
          end else begin
            st_cnt <= st_cnt + SW'(1);
          end
        end
        UPDATE: begin
          state   <= IDLE;
          o_valid <= 1'b1;
          o_fault <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RECT_ADC_AVG_EN
  logic [7:0] hist_i [4];
  logic [7:0] hist_v [4];
  logic [9:0] sum_i, sum_v;

  // NOTE: the history feeds the outputs directly, so it is reset like any other visible state.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      for (int k = 0; k < 4; k++) begin
        hist_i[k] <= '0;
        hist_v[k] <= '0;
      end
    end else if (state == UPDATE) begin
      hist_i[0] <= shadow_i;
      hist_v[0] <= shadow_v;
      for (int k = 1; k < 4; k++) begin
        hist_i[k] <= hist_i[k-1];
        hist_v[k] <= hist_v[k-1];
      end
    end
  end

  always_comb begin
    sum_i = 10'(hist_i[0]) + 10'(hist_i[1]) + 10'(hist_i[2]) + 10'(hist_i[3]);
    sum_v = 10'(hist_v[0]) + 10'(hist_v[1]) + 10'(hist_v[2]) + 10'(hist_v[3]);
  end

  assign o_Ibat_ADC = 8'(sum_i >> 2);
  assign o_Vbat_ADC = 8'(sum_v >> 2);
`else
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      o_Ibat_ADC <= '0;
      o_Vbat_ADC <= '0;
    end else if (state == UPDATE) begin
      o_Ibat_ADC <= shadow_i;
      o_Vbat_ADC <= shadow_v;
    end
  end
`endif

endmodule

// File: tb/tb_rectifier_adc_sequencer.sv
// Self-checking bench for rectifier_adc_sequencer: ADC model plus an expected-sample scoreboard.
// Define RECT_ADC_AVG_EN for both files to exercise the averaging build.
module tb_rectifier_adc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       eoc_i_n = 1'b1, eoc_v_n = 1'b1;
  logic [7:0] bus_i = 8'h00, bus_v = 8'h00;
  logic       convst_n, cs_i_n, rd_i_n, cs_v_n, rd_v_n;
  logic [7:0] ibat, vbat;
  logic       valid, fault, busy;

  rectifier_adc_sequencer dut (
    .i_CLK      (clk),
    .i_RST_n    (rst_n),
    .i_enable   (enable),
    .i_EOC_I_n  (eoc_i_n),
    .i_EOC_V_n  (eoc_v_n),
    .i_DATA_I   (bus_i),
    .i_DATA_V   (bus_v),
    .o_CONVST_n (convst_n),
    .o_CS_I_n   (cs_i_n),
    .o_RD_I_n   (rd_i_n),
    .o_CS_V_n   (cs_v_n),
    .o_RD_V_n   (rd_v_n),
    .o_Ibat_ADC (ibat),
    .o_Vbat_ADC (vbat),
    .o_valid    (valid),
    .o_fault    (fault),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         fault;
    logic [7:0] i;
    logic [7:0] v;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0, n_fail = 0;
  int         cyc = 0, age = 0;
  bit         age_run = 0;
  int         dly_i = 20, dly_v = 20;
  logic [7:0] data_i = 8'h98, data_v = 8'h5A;
  logic       prev_convst = 1'b1, prev_fault = 1'b0, prev_rd_i = 1'b1, prev_rd_v = 1'b1;
  int         n_convst = 0, n_valid = 0, n_rd_fall = 0;
  int         rd_i_fall_cyc = 0, rd_v_fall_cyc = 0, rd_i_fall_age = 0;
`ifdef RECT_ADC_AVG_EN
  logic [7:0] hm_i [4];
  logic [7:0] hm_v [4];
`endif

  // One clock of the ADC model and the scoreboard, evaluated on the falling edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (age_run) age++;
    if (prev_convst && !convst_n) begin
      age = 0;
      age_run = 1;
      n_convst++;
      e.fault = (dly_i < 0) || (dly_v < 0);
      e.i = 8'h00;
      e.v = 8'h00;
      if (!e.fault) begin
`ifdef RECT_ADC_AVG_EN
        for (int k = 3; k > 0; k--) begin
          hm_i[k] = hm_i[k-1];
          hm_v[k] = hm_v[k-1];
        end
        hm_i[0] = data_i;
        hm_v[0] = data_v;
        e.i = 8'((10'(hm_i[0]) + 10'(hm_i[1]) + 10'(hm_i[2]) + 10'(hm_i[3])) >> 2);
        e.v = 8'((10'(hm_v[0]) + 10'(hm_v[1]) + 10'(hm_v[2]) + 10'(hm_v[3])) >> 2);
`else
        e.i = data_i;
        e.v = data_v;
`endif
      end
      sb.push_back(e);
    end
    eoc_i_n = !(age_run && dly_i >= 0 && age >= dly_i && age < dly_i + 3);
    eoc_v_n = !(age_run && dly_v >= 0 && age >= dly_v && age < dly_v + 3);
    bus_i = (!cs_i_n && !rd_i_n) ? data_i : 8'h00;
    bus_v = (!cs_v_n && !rd_v_n) ? data_v : 8'h00;
    if (prev_rd_i && !rd_i_n) begin
      rd_i_fall_cyc = cyc;
      rd_i_fall_age = age;
      n_rd_fall++;
    end
    if (prev_rd_v && !rd_v_n) begin
      rd_v_fall_cyc = cyc;
      n_rd_fall++;
    end
    if ((!cs_i_n || !rd_i_n) && (!cs_v_n || !rd_v_n)) begin
      n_checks++;
      n_fail++;
      $display("FAIL overlap: I and V read pins low together at cycle %0d", cyc);
    end
    if (valid) begin
      n_valid++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_valid: o_valid with no conversion pending at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        if (e.fault || ibat !== e.i || vbat !== e.v || fault !== 1'b0) begin
          n_fail++;
          $display("FAIL sb_valid: got I=%h V=%h fault=%b, expected timeout=%0d I=%h V=%h fault=0",
                   ibat, vbat, fault, e.fault, e.i, e.v);
        end
      end
    end
    if (fault && !prev_fault) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_fault: o_fault rose with no conversion pending at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        if (!e.fault) begin
          n_fail++;
          $display("FAIL sb_fault: o_fault rose, expected a completed read of I=%h V=%h", e.i, e.v);
        end
      end
    end
    prev_convst = convst_n;
    prev_fault  = fault;
    prev_rd_i   = rd_i_n;
    prev_rd_v   = rd_v_n;
  endtask

  // which: 0 new o_valid, 1 CONVST low, 2 RD_I low, 3 RD_V low, 4 CONVST high
  task automatic wait_for(input int which, input int budget, output bit ok);
    int base;
    base = n_valid;
    ok = 0;
    for (int t = 0; t < budget && !ok; t++) begin
      cycle();
      case (which)
        0: ok = (n_valid != base);
        1: ok = !convst_n;
        2: ok = !rd_i_n;
        3: ok = !rd_v_n;
        default: ok = convst_n;
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    repeat (3) cycle();
    n_checks++;
    if (convst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_convst: got %b expected 1", convst_n);
    end
    n_checks++;
    if ({cs_i_n, rd_i_n, cs_v_n, rd_v_n} !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_rd_pins: got %b expected 1111", {cs_i_n, rd_i_n, cs_v_n, rd_v_n});
    end
    n_checks++;
    if (ibat !== 8'h00 || vbat !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_samples: got I=%h V=%h expected 00 00", ibat, vbat);
    end
    n_checks++;
    if ({valid, fault, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/fault/busy=%b expected 000", {valid, fault, busy});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_period();
    int first, width, fall_cyc;
    bit ok;
    first = 600;
    for (int t = 1; t <= 600; t++) begin
      cycle();
      if (!convst_n) begin
        first = t;
        break;
      end
    end
    n_checks++;
    if (first != 500) begin
      n_fail++;
      $display("FAIL first_convst: first low after %0d cycles, expected 500", first);
    end
    fall_cyc = cyc;
    width = 1;
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (convst_n) break;
      width++;
    end
    n_checks++;
    if (width != 3) begin
      n_fail++;
      $display("FAIL convst_width: low for %0d cycles, expected 3", width);
    end
    wait_for(1, 600, ok);
    n_checks++;
    if (!ok || cyc - fall_cyc != 500) begin
      n_fail++;
      $display("FAIL convst_period: got %0d cycles (seen=%0d), expected 500", cyc - fall_cyc, ok);
    end
    n_checks++;
    if (n_valid != 1) begin
      n_fail++;
      $display("FAIL valid_count: got %0d pulses in first period, expected 1", n_valid);
    end
  endtask

  task automatic test_read();
    bit ok;
    wait_for(0, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL read_done: no o_valid within 100 cycles, expected one");
    end
    n_checks++;
    if (rd_v_fall_cyc - rd_i_fall_cyc != 4) begin
      n_fail++;
      $display("FAIL rd_spacing: RD_V fell %0d cycles after RD_I, expected 4", rd_v_fall_cyc - rd_i_fall_cyc);
    end
    n_checks++;
    if (ibat !== 8'h98 || vbat !== 8'h5A) begin
      n_fail++;
      $display("FAIL read_data: got I=%h V=%h expected 98 5a", ibat, vbat);
    end
    cycle();
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_pulse: got valid=%b busy=%b after update, expected 0 0", valid, busy);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int w, rd_base;
    dly_v = -1;
    wait_for(1, 600, ok);
    wait_for(4, 10, ok);
    rd_base = n_rd_fall;
    w = 1;
    for (int t = 0; t < 100; t++) begin
      cycle();
      if (!busy) break;
      w++;
    end
    n_checks++;
    if (w != 50) begin
      n_fail++;
      $display("FAIL wait_length: WAIT lasted %0d cycles, expected 50", w);
    end
    n_checks++;
    if (n_rd_fall != rd_base) begin
      n_fail++;
      $display("FAIL timeout_no_read: got %0d read pulses, expected 0", n_rd_fall - rd_base);
    end
    n_checks++;
    if (fault !== 1'b1 || ibat !== 8'h98 || vbat !== 8'h5A) begin
      n_fail++;
      $display("FAIL timeout_hold: got fault=%b I=%h V=%h expected 1 98 5a", fault, ibat, vbat);
    end
    dly_v = 20;
    data_i = 8'h33;
    data_v = 8'hC4;
  endtask

  task automatic test_recover();
    bit ok;
    wait_for(0, 600, ok);
    n_checks++;
    if (!ok || fault !== 1'b0 || ibat !== 8'h33 || vbat !== 8'hC4) begin
      n_fail++;
      $display("FAIL recover: got valid_seen=%0d fault=%b I=%h V=%h expected 1 0 33 c4", ok, fault, ibat, vbat);
    end
  endtask

  task automatic test_skewed();
    bit ok;
    dly_i = 10;
    dly_v = 30;
    data_i = 8'h01;
    data_v = 8'hFE;
    wait_for(0, 600, ok);
    n_checks++;
    if (!ok || rd_i_fall_age < dly_v + 3 || rd_i_fall_age > dly_v + 6) begin
      n_fail++;
      $display("FAIL skew_rd_start: RD_I fell %0d cycles after CONVST (valid_seen=%0d), expected %0d..%0d",
               rd_i_fall_age, ok, dly_v + 3, dly_v + 6);
    end
    n_checks++;
    if (ibat !== 8'h01 || vbat !== 8'hFE) begin
      n_fail++;
      $display("FAIL skew_data: got I=%h V=%h expected 01 fe", ibat, vbat);
    end
  endtask

  task automatic test_disable();
    bit ok;
    int base;
    dly_i = 20;
    dly_v = 20;
    data_i = 8'h44;
    data_v = 8'h55;
    wait_for(2, 600, ok);
    enable = 1'b0;
    wait_for(0, 50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL disable_update: no o_valid after enable dropped, expected one");
    end
    base = n_convst;
    repeat (1200) cycle();
    n_checks++;
    if (n_convst != base || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_idle: got %0d new starts busy=%b expected 0 0", n_convst - base, busy);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    enable = 1'b1;
    wait_for(3, 700, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rd_v_reached: RD_V never went low after re-enable");
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({convst_n, cs_i_n, rd_i_n, cs_v_n, rd_v_n} !== 5'h1F) begin
      n_fail++;
      $display("FAIL midread_pins: got %b expected 11111", {convst_n, cs_i_n, rd_i_n, cs_v_n, rd_v_n});
    end
    n_checks++;
    if (ibat !== 8'h00 || vbat !== 8'h00 || {valid, fault, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL midread_outputs: got I=%h V=%h flags=%b expected 00 00 000", ibat, vbat, {valid, fault, busy});
    end
    sb.delete();
    age_run = 0;
`ifdef RECT_ADC_AVG_EN
    for (int k = 0; k < 4; k++) begin
      hm_i[k] = 8'h00;
      hm_v[k] = 8'h00;
    end
`endif
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

`ifdef RECT_ADC_AVG_EN
  task automatic test_average();
    logic [7:0] want [4];
    bit ok;
    want[0] = 8'h04;
    want[1] = 8'h0C;
    want[2] = 8'h18;
    want[3] = 8'h28;
    for (int k = 0; k < 4; k++) begin
      data_i = 8'((k + 1) * 16);
      data_v = 8'h80;
      wait_for(0, 600, ok);
      n_checks++;
      if (!ok || ibat !== want[k]) begin
        n_fail++;
        $display("FAIL avg_%0d: got I=%h (valid_seen=%0d) expected %h", k, ibat, ok, want[k]);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    bit ok;
    for (int k = 0; k < 4; k++) begin
      data_i = 8'($urandom_range(0, 255));
      data_v = 8'($urandom_range(0, 255));
      dly_i = int'($urandom_range(5, 25));
      dly_v = int'($urandom_range(5, 25));
      wait_for(0, 600, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL b2b_%0d: no o_valid within 600 cycles", k);
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d conversions unaccounted, expected 0", sb.size());
    end
  endtask

  initial begin
`ifdef RECT_ADC_AVG_EN
    for (int k = 0; k < 4; k++) begin
      hm_i[k] = 8'h00;
      hm_v[k] = 8'h00;
    end
`endif
    test_reset();
    test_period();
    test_read();
    test_timeout();
    test_recover();
    test_skewed();
    test_disable();
    test_reset_mid_read();
`ifdef RECT_ADC_AVG_EN
    test_average();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rectifier_adc_sequencer.md
Name: rectifier_adc_sequencer

Overview:
Sequences the two AD7822 8-bit ADCs on the rectifier board: battery current and battery voltage. It fires a common conversion start at a fixed sample rate and waits for both end-of-conversion pulses. It then reads each converter in turn and presents held samples, with a valid strobe, to the sensing_Ibat / sensing_Vbat conversion logic and the control loop. It is the only block that drives the ADC control pins.

Parameters:
SAMPLE_DIV, 500, clock cycles between conversion starts (100 kHz at 50 MHz); must be >= CONVST_W+EOC_TIMEOUT+2*RD_W+6
CONVST_W, 3, cycles o_CONVST_n is held low
EOC_TIMEOUT, 50, max cycles in WAIT before the conversion is abandoned
RD_W, 4, cycles CS/RD are held low per read; data is sampled on the last one

Ports:
i_CLK  in  1  system clock
i_RST_n  in  1  asynchronous active-low reset
i_enable  in  1  run conversions while high
i_EOC_I_n  in  1  Ibat ADC end-of-conversion, active low, asynchronous
i_EOC_V_n  in  1  Vbat ADC end-of-conversion, active low, asynchronous
i_DATA_I  in  8  Ibat ADC data bus
i_DATA_V  in  8  Vbat ADC data bus
o_CONVST_n  out  1  common conversion start to both ADCs
o_CS_I_n  out  1  Ibat ADC chip select
o_RD_I_n  out  1  Ibat ADC read
o_CS_V_n  out  1  Vbat ADC chip select
o_RD_V_n  out  1  Vbat ADC read
o_Ibat_ADC  out  8  held Ibat sample
o_Vbat_ADC  out  8  held Vbat sample
o_valid  out  1  one-cycle pulse when new samples are loaded
o_fault  out  1  set on EOC timeout, cleared by next successful cycle
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous and active low, one clock:
  - o_CONVST_n, CS, RD = 1
  - samples = 0; o_valid, o_fault, o_busy = 0
  - state IDLE; period counter = SAMPLE_DIV-1
- EOC inputs pass through a 2-flop synchronizer. A per-channel "seen" flag sets on a synchronized low level. Flags are cleared on entry to CONV.
- Period counter:
  - Decrements each cycle while i_enable = 1 and reloads SAMPLE_DIV-1 at 0.
  - The tick is the cycle at 0.
  - i_enable = 0 holds the counter at reload.
- IDLE: on tick with i_enable = 1, go to CONV. A tick arriving outside IDLE is dropped; there is no queuing.
- CONV: o_CONVST_n = 0 for exactly CONVST_W cycles, then WAIT.
- WAIT:
  - Both seen flags set: go to RD_I.
  - Counter reaches EOC_TIMEOUT: go to IDLE, set o_fault, no read, outputs unchanged.
- RD_I:
  - o_CS_I_n = o_RD_I_n = 0 for RD_W cycles.
  - i_DATA_I is captured into a shadow register on the last cycle, then RD_V.
- RD_V: same as RD_I on the V pins, then UPDATE. The CS_I/RD_I and CS_V/RD_V pairs are never low simultaneously.
- UPDATE:
  - o_Ibat_ADC and o_Vbat_ADC load from the shadows.
  - o_valid = 1 for this single cycle; o_fault cleared.
  - Then IDLE.
- Latency from the CONVST falling edge to o_valid = CONVST_W + (EOC wait incl. 2 sync) + 2*RD_W + 1 cycles. Outputs change only in UPDATE.
- i_enable falling mid-cycle: the current cycle completes, including UPDATE; no new start.
- An EOC pulse arriving outside WAIT/CONV is ignored because the flags clear at CONV entry.
- Reset mid-read forces all control pins high immediately.

Optional Feature:
- Macro: RECT_ADC_AVG_EN.
- Defined:
  - Each channel keeps a 4-deep history of raw samples, all 0 at reset, shifted in UPDATE.
  - Outputs = (sum of 4, 10-bit) >> 2, truncated.
  - o_valid timing is unchanged.
- Undefined: outputs are raw samples and no history registers exist.

Test Plan:
1. Reset release, i_enable = 1, SAMPLE_DIV = 500:
   - first o_CONVST_n low after 500 cycles, for 3 cycles
   - then repeats every 500 cycles.
2. Model EOCs low 20 cycles after CONVST, data I = 0x98, V = 0x5A:
   - o_Ibat_ADC = 0x98, o_Vbat_ADC = 0x5A, one o_valid pulse
   - RD_I low exactly 4 cycles before RD_V, never overlapping.
3. Vbat EOC never asserted:
   - WAIT lasts 50 cycles, no RD pulses, o_fault = 1, outputs keep the previous values.
   - Next cycle with both EOCs asserted clears o_fault with o_valid.
4. Ibat EOC at +10 cycles, Vbat EOC at +30 cycles:
   - RD_I starts only after the Vbat EOC is synchronized; both samples correct.
5. Drop i_enable during RD_I:
   - UPDATE still occurs; no further CONVST; o_busy = 0 afterwards.
   - Assert i_RST_n low during RD_V: all pins high and outputs 0 within the same cycle.
6. With RECT_ADC_AVG_EN, Ibat samples 0x10, 0x20, 0x30, 0x40:
   - outputs 0x04, 0x0C, 0x18, 0x28.
